// File: rtl/depipe_pkg.sv
// Shared widths and control-bundle types for the Decode-to-Execute register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package depipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 4;

    // Single-bit Decode control flags, in the order they travel down the pipe.
    typedef struct packed {
        logic pcload;
        logic regw;
        logic memw;
        logic regmem;
        logic branch;
        logic alu_ope;
        logic flag;
    } ctrl_flags_t;

    // Full control bundle at the default control width.
    typedef struct packed {
        ctrl_flags_t               flags;
        logic [CTRL_W_DEF-1:0]     alu_ctrl;
        logic [CTRL_W_DEF-1:0]     reg_scr;
    } ctrl_t;

    localparam int CTRL_FLAGS_W = $bits(ctrl_flags_t);

endpackage

// File: rtl/depipe_pipe_reg.sv
// Generic pipeline flop with async clear and synchronous flush-to-zero.
// Latency: 1 clock from d to q.
// Backpressure: none; captures on every rising edge, flush inserts a zero bubble.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset clears immediately and dominates flush; flush beats normal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/depipe.sv
// Decode-to-Execute pipeline register; flush turns the Execute stage into a NOP.
// Latency: 1 clock, all outputs straight from flops.
// Backpressure: none; no stall input, a new Decode word is taken every edge.
module depipe
    import depipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_E,

    input  logic              pcload_D,
    input  logic              regw_D,
    input  logic              memw_D,
    input  logic              regmem_D,
    input  logic              branch_D,
    input  logic              ALUope_D,
    input  logic              flag_D,
    input  logic [CTRL_W-1:0] ALUctrl_D,
    input  logic [CTRL_W-1:0] regScr_D,
    input  logic [DATA_W-1:0] regA_D,
    input  logic [DATA_W-1:0] regB_D,
    input  logic [DATA_W-1:0] inm_D,

    output logic              pcload_E,
    output logic              regw_E,
    output logic              memw_E,
    output logic              regmem_E,
    output logic              branch_E,
    output logic              ALUope_E,
    output logic              flag_E,
    output logic [CTRL_W-1:0] ALUctrl_E,
    output logic [CTRL_W-1:0] regScr_E,
    output logic [DATA_W-1:0] regA_E,
    output logic [DATA_W-1:0] regB_E,
    output logic [DATA_W-1:0] inm_E
);

    ctrl_flags_t             flags_d;
    ctrl_flags_t             flags_q;
    logic [2*CTRL_W-1:0]     code_d;
    logic [2*CTRL_W-1:0]     code_q;
    logic [3*DATA_W-1:0]     data_d;
    logic [3*DATA_W-1:0]     data_q;

    // Gather the Decode-side flags into the shared flag bundle.
    always_comb begin
        flags_d         = '0;
        flags_d.pcload  = pcload_D;
        flags_d.regw    = regw_D;
        flags_d.memw    = memw_D;
        flags_d.regmem  = regmem_D;
        flags_d.branch  = branch_D;
        flags_d.alu_ope = ALUope_D;
        flags_d.flag    = flag_D;
    end

    assign code_d = {ALUctrl_D, regScr_D};
    assign data_d = {regA_D, regB_D, inm_D};

    pipe_reg #(.W(CTRL_FLAGS_W)) u_flags_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_E),
        .d     (flags_d),
        .q     (flags_q)
    );

    pipe_reg #(.W(2*CTRL_W)) u_code_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_E),
        .d     (code_d),
        .q     (code_q)
    );

    pipe_reg #(.W(3*DATA_W)) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_E),
        .d     (data_d),
        .q     (data_q)
    );

    assign pcload_E  = flags_q.pcload;
    assign regw_E    = flags_q.regw;
    assign memw_E    = flags_q.memw;
    assign regmem_E  = flags_q.regmem;
    assign branch_E  = flags_q.branch;
    assign ALUope_E  = flags_q.alu_ope;
    assign flag_E    = flags_q.flag;

    assign ALUctrl_E = code_q[2*CTRL_W-1:CTRL_W];
    assign regScr_E  = code_q[CTRL_W-1:0];

    assign regA_E    = data_q[3*DATA_W-1:2*DATA_W];
    assign regB_E    = data_q[2*DATA_W-1:DATA_W];
    assign inm_E     = data_q[DATA_W-1:0];

endmodule

// File: tb/tb_depipe.sv
// Self-checking bench for depipe: directed scenarios then randomized traffic.
// Latency: expects one clock from Decode inputs to Execute outputs.
// Backpressure: none exercised; flush and async reset are driven as bubbles.
module tb_depipe;

    typedef struct packed {
        logic        pcload;
        logic        regw;
        logic        memw;
        logic        regmem;
        logic        branch;
        logic        alu_ope;
        logic        flag;
        logic [3:0]  alu_ctrl;
        logic [3:0]  reg_scr;
        logic [31:0] reg_a;
        logic [31:0] reg_b;
        logic [31:0] inm;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush_E;
    vec_t din;
    vec_t obs;
    vec_t model;
    vec_t v1;
    vec_t v2;
    vec_t vr;
    vec_t zero_v;
    logic [127:0] rnd;

    int checks;
    int errors;

    logic        pcload_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E;
    logic [3:0]  ALUctrl_E, regScr_E;
    logic [31:0] regA_E, regB_E, inm_E;

    depipe #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_E   (flush_E),
        .pcload_D  (din.pcload),
        .regw_D    (din.regw),
        .memw_D    (din.memw),
        .regmem_D  (din.regmem),
        .branch_D  (din.branch),
        .ALUope_D  (din.alu_ope),
        .flag_D    (din.flag),
        .ALUctrl_D (din.alu_ctrl),
        .regScr_D  (din.reg_scr),
        .regA_D    (din.reg_a),
        .regB_D    (din.reg_b),
        .inm_D     (din.inm),
        .pcload_E  (pcload_E),
        .regw_E    (regw_E),
        .memw_E    (memw_E),
        .regmem_E  (regmem_E),
        .branch_E  (branch_E),
        .ALUope_E  (ALUope_E),
        .flag_E    (flag_E),
        .ALUctrl_E (ALUctrl_E),
        .regScr_E  (regScr_E),
        .regA_E    (regA_E),
        .regB_E    (regB_E),
        .inm_E     (inm_E)
    );

    assign obs = {pcload_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E,
                  ALUctrl_E, regScr_E, regA_E, regB_E, inm_E};

    // Free-running clock, first rising edge at 5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return vec_t'(r[110:0]);
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        zero_v  = '0;
        rst_n   = 1'b1;
        flush_E = 1'b0;
        din     = '1;
        rnd     = '0;

        v1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
               4'b0101, 4'b0011, 32'h0000FFFF, 32'h00000801, 32'h00000000};
        v2 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               4'b0010, 4'b0100, 32'h0000FFFF, 32'h00000000, 32'h00000401};

        // Async reset with all inputs non-zero, before any clock edge.
        #1 rst_n = 1'b0;
        #1 check("reset_async_no_edge", zero_v);

        // Edges while in reset must not capture.
        din = rand_vec() | vec_t'(111'h1);
        @(posedge clk); #1 check("reset_hold_edge1", zero_v);
        @(posedge clk); #1 check("reset_hold_edge2", zero_v);

        // Release and run all-zero inputs for three cycles.
        @(negedge clk);
        rst_n = 1'b1;
        din   = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 check("zero_inputs", zero_v);
        end

        // First pattern applied mid-cycle: not visible until the edge.
        @(negedge clk);
        #2 din = v1;
        #1 check("v1_before_edge", zero_v);
        @(posedge clk); #1 check("v1_capture", v1);

        // Second pattern: previous value held until the edge.
        @(negedge clk);
        din = v2;
        #1 check("v2_hold_prev", v1);
        @(posedge clk); #1 check("v2_capture", v2);

        // Flush held for two edges, then released.
        @(negedge clk);
        flush_E = 1'b1;
        #1 check("flush_before_edge", v2);
        @(posedge clk); #1 check("flush_edge1", zero_v);
        @(posedge clk); #1 check("flush_edge2", zero_v);
        @(negedge clk);
        flush_E = 1'b0;
        #1 check("flush_release_hold", zero_v);
        @(posedge clk); #1 check("after_flush_capture", v2);

        // Mid-cycle async reset while outputs are non-zero.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midcycle_reset", zero_v);
        @(posedge clk); #1 check("midcycle_reset_edge", zero_v);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_release_hold", zero_v);
        @(posedge clk); #1 check("reset_resume_capture", v2);

        // Several input changes between edges: only the last one counts.
        @(negedge clk);
        din = v1;
        #2 vr = rand_vec();
        din = vr;
        #1 check("glitch_no_effect", v2);
        @(posedge clk); #1 check("glitch_last_value", vr);

        // Reset dominates flush.
        @(negedge clk);
        flush_E = 1'b1;
        rst_n   = 1'b0;
        #1 check("reset_with_flush", zero_v);
        @(negedge clk);
        rst_n   = 1'b1;
        flush_E = 1'b0;
        din     = v1;
        @(posedge clk); #1 check("after_reset_flush", v1);

        // Randomized traffic against a last-sampled-value model.
        model = v1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst_n   = 1'b1;
            din     = rand_vec();
            flush_E = ($urandom_range(3) == 0);
            @(posedge clk);
            model = flush_E ? zero_v : din;
            #1 check("rand_step", model);
            if ($urandom_range(15) == 0) begin
                #1;
                flush_E = $urandom_range(1);
                rst_n   = 1'b0;
                model   = zero_v;
                #1 check("rand_async_reset", model);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/depipe.md
DEPIPE -- requirements
Module: depipe

Interface
REQ-001 Parameter DATA_W, default 32, width of regA/regB/inm paths.
REQ-002 Parameter CTRL_W, default 4, width of ALUctrl and regScr fields.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 flush_E  input  1  synchronous flush of Execute-stage contents.
REQ-006 pcload_D, regw_D, memw_D, regmem_D, branch_D, ALUope_D, flag_D  input  1 each  Decode-stage control bits (PC load, reg write, mem write, reg-from-mem select, branch, ALU-operand select, flag update).
REQ-007 ALUctrl_D, regScr_D  input  CTRL_W each  ALU operation code; destination/source register index.
REQ-008 regA_D, regB_D, inm_D  input  DATA_W each  operand A, operand B, immediate; narrower immediates arrive zero-extended.
REQ-009 pcload_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E  output  1 each  registered copies of the _D bits.
REQ-010 ALUctrl_E, regScr_E  output  CTRL_W each; regA_E, regB_E, inm_E  output  DATA_W each  registered copies.

Function
REQ-011 The block SHALL be a Decode-to-Execute pipeline register: each _E output is a flop holding its _D input.
REQ-012 Latency SHALL be exactly one clock: value at _D sampled on rising edge N appears on _E after edge N and holds until edge N+1.
REQ-013 Outputs SHALL be driven only from flops; no combinational path from any input to any output.
REQ-014 With flush_E=1 at a rising edge, every _E output SHALL load 0 (bubble/NOP), regardless of _D values.
REQ-015 flush_E SHALL take priority over data capture; flush_E=0 SHALL capture _D normally.
REQ-016 flush_E held high for multiple cycles SHALL keep all outputs 0 for each of those edges.
REQ-017 Input changes between edges SHALL have no effect on outputs until the next rising edge.
REQ-018 All fields SHALL capture bit-exact; no sign extension, masking or arithmetic.

Reset
REQ-019 rst_n=0 SHALL immediately (asynchronously) force every _E output to 0.
REQ-020 While rst_n=0, rising edges SHALL not change outputs; first capture occurs on the first rising edge with rst_n=1.
REQ-021 Reset asserted mid-operation SHALL discard held contents; reset dominates flush.

Structure
REQ-022 A shared package SHALL hold DATA_W/CTRL_W defaults and a packed struct typedef for the D/E control bundle (seven 1-bit fields plus ALUctrl and regScr).
REQ-023 One sub-module pipe_reg (parameterised width, clk, rst_n, flush, d, q) SHALL implement the reset/flush flop; depipe instantiates it per field or per bundle.

Verification
REQ-024 rst_n=0 with all _D non-zero -> all _E = 0 immediately, before any clock edge.
REQ-025 All _D=0, run 3 cycles -> all _E=0.
REQ-026 pcload=1, regw=1, branch=1, flag=1, others 0, ALUctrl=0101, regScr=0011, regA=0000FFFF, regB=00000801, inm=0 applied mid-cycle -> exactly these values on _E after next rising edge, not before.
REQ-027 Next cycle regw=1, ALUope=1, others 0, ALUctrl=0010, regScr=0100, regA=0000FFFF, regB=0, inm=00000401 -> _E matches after one edge; previous values held until that edge.
REQ-028 flush_E=1 with REQ-027 inputs still applied, held 2 cycles -> all _E = 0 after the first edge and remain 0; deassert flush -> inputs captured on the following edge.
REQ-029 Assert rst_n=0 between edges while flush_E=0 and outputs non-zero -> outputs 0 at once; release -> capture resumes on next edge.
